// File: rtl/nim_disp_pkg.sv
// rtl/nim_disp_pkg.sv - shared types and constants for the Nim display formatter
package nim_disp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      SHOW,
      WIN
   } state_e;

   localparam int MAX_PILE    = 99;
   localparam int BIN_W       = 8;
   localparam int BCD_W       = 4;
   localparam int CONV_CYCLES = 8;

   // Piles above two decimal digits are clamped so the display never needs a hundreds digit.
   function automatic logic [BIN_W-1:0] sat_pile(input logic [BIN_W-1:0] p);
      return (p > BIN_W'(MAX_PILE)) ? BIN_W'(MAX_PILE) : p;
   endfunction

endpackage

// File: rtl/nim_display_formatter_if.sv
// rtl/nim_display_formatter_if.sv - game-state in, digit codes and blank mask out
interface nim_display_formatter_if;
   import nim_disp_pkg::*;

   logic             upd_valid;
   logic [BIN_W-1:0] pile;
   logic             player;
   logic [1:0]       take;
   logic             game_over;
   logic             busy;
   logic [BCD_W-1:0] in3;
   logic [BCD_W-1:0] in2;
   logic [BCD_W-1:0] in1;
   logic [BCD_W-1:0] in0;
   logic [3:0]       blank;

   modport master (
      output upd_valid, pile, player, take, game_over,
      input  busy, in3, in2, in1, in0, blank
   );

   modport slave (
      input  upd_valid, pile, player, take, game_over,
      output busy, in3, in2, in1, in0, blank
   );

endinterface

// File: rtl/nim_bin2bcd.sv
// rtl/nim_bin2bcd.sv - sequential 8-bit to two-digit BCD double-dabble, one shift per clock
module nim_bin2bcd
   import nim_disp_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             done,
   output logic [BCD_W-1:0] tens,
   output logic [BCD_W-1:0] ones
);

   logic [BIN_W-1:0]   bin_q, bin_d;
   logic [2*BCD_W-1:0] bcd_q, bcd_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               run_q, run_d;
   logic               done_q, done_d;
   logic [2*BCD_W-1:0] bcd_adj;

   always_comb begin
      bcd_adj = bcd_q;
      if (bcd_q[3:0] >= 4'd5) begin
         bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
      end
      if (bcd_q[7:4] >= 4'd5) begin
         bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
      end
   end

   always_comb begin
      bin_d  = bin_q;
      bcd_d  = bcd_q;
      cnt_d  = cnt_q;
      run_d  = run_q;
      done_d = 1'b0;
      if (start) begin
         bin_d = bin;
         bcd_d = '0;
         cnt_d = '0;
         run_d = 1'b1;
      end else if (run_q) begin
         {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
         cnt_d          = cnt_q + 4'd1;
         // done pulses on the edge of the last shift so the result is stable one cycle later
         if (cnt_q == 4'(CONV_CYCLES - 1)) begin
            run_d  = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         bcd_q  <= bcd_d;
         cnt_q  <= cnt_d;
         run_q  <= run_d;
         done_q <= done_d;
      end
   end

   assign done = done_q;
   assign tens = bcd_q[7:4];
   assign ones = bcd_q[3:0];

endmodule

// File: rtl/nim_display_formatter.sv
// rtl/nim_display_formatter.sv - Nim game state to four display digits with winner blink mask
module nim_display_formatter
   import nim_disp_pkg::*;
#(
   parameter int BLINK_DIV   = 25_000_000,
   parameter int WIN_TOGGLES = 6
) (
   input logic                    clk,
   input logic                    rst_n,
   nim_display_formatter_if.slave bus
);

   localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam int TW = $clog2(WIN_TOGGLES + 1);
   localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);
   localparam logic [TW-1:0] TOG_LAST   = TW'(WIN_TOGGLES);

   state_e           state_q, state_d;
   logic             player_q, player_d;
   logic [1:0]       take_q, take_d;
   logic             go_q, go_d;
   logic [BCD_W-1:0] in3_q, in3_d;
   logic [BCD_W-1:0] in2_q, in2_d;
   logic [BCD_W-1:0] in1_q, in1_d;
   logic [BCD_W-1:0] in0_q, in0_d;
   logic [3:0]       blank_q, blank_d;
   logic [CW-1:0]    blink_q, blink_d;
   logic [TW-1:0]    tog_q, tog_d;

   logic             accept;
   logic             bcd_start;
   logic             bcd_done;
   logic [BIN_W-1:0] pile_sat;
   logic [BCD_W-1:0] bcd_tens;
   logic [BCD_W-1:0] bcd_ones;

   assign pile_sat = sat_pile(bus.pile);
   assign accept   = bus.upd_valid && (state_q != CONV);

   nim_bin2bcd u_bin2bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (bcd_start),
      .bin   (pile_sat),
      .done  (bcd_done),
      .tens  (bcd_tens),
      .ones  (bcd_ones)
   );

   always_comb begin
      state_d   = state_q;
      player_d  = player_q;
      take_d    = take_q;
      go_d      = go_q;
      in3_d     = in3_q;
      in2_d     = in2_q;
      in1_d     = in1_q;
      in0_d     = in0_q;
      blank_d   = blank_q;
      blink_d   = blink_q;
      tog_d     = tog_q;
      bcd_start = 1'b0;

      case (state_q)
         CONV: begin
            if (bcd_done) begin
               in3_d   = {3'b000, player_q} + 4'd1;
               in2_d   = {2'b00, take_q};
               in1_d   = bcd_tens;
               in0_d   = bcd_ones;
               state_d = go_q ? WIN : SHOW;
               blank_d = '0;
               blink_d = '0;
               tog_d   = '0;
            end
         end
         WIN: begin
            if (tog_q != TOG_LAST) begin
               if (blink_q == BLINK_LAST) begin
                  blink_d = '0;
                  blank_d = ~blank_q;
                  tog_d   = tog_q + TW'(1);
               end else begin
                  blink_d = blink_q + CW'(1);
               end
            end else begin
               blank_d = '0;
            end
         end
         default: ;
      endcase

      // An accept wins over any blink terminal count landing on the same edge.
      if (accept) begin
         player_d  = bus.player;
         take_d    = bus.take;
         go_d      = bus.game_over;
         state_d   = CONV;
         blank_d   = '0;
         blink_d   = '0;
         tog_d     = '0;
         bcd_start = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         player_q <= 1'b0;
         take_q   <= '0;
         go_q     <= 1'b0;
         in3_q    <= '0;
         in2_q    <= '0;
         in1_q    <= '0;
         in0_q    <= '0;
         blank_q  <= '0;
         blink_q  <= '0;
         tog_q    <= '0;
      end else begin
         state_q  <= state_d;
         player_q <= player_d;
         take_q   <= take_d;
         go_q     <= go_d;
         in3_q    <= in3_d;
         in2_q    <= in2_d;
         in1_q    <= in1_d;
         in0_q    <= in0_d;
         blank_q  <= blank_d;
         blink_q  <= blink_d;
         tog_q    <= tog_d;
      end
   end

   assign bus.busy  = (state_q == CONV);
   assign bus.in3   = in3_q;
   assign bus.in2   = in2_q;
   assign bus.in1   = in1_q;
   assign bus.in0   = in0_q;
   assign bus.blank = blank_q;

endmodule

// File: tb/tb_nim_display_formatter.sv
// tb/tb_nim_display_formatter.sv - scoreboard bench for nim_display_formatter
module tb_nim_display_formatter;
   import nim_disp_pkg::*;

   localparam int BLINK_DIV   = 4;
   localparam int WIN_TOGGLES = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   nim_display_formatter_if bus();

   nim_display_formatter #(
      .BLINK_DIV   (BLINK_DIV),
      .WIN_TOGGLES (WIN_TOGGLES)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [15:0] sb[$];
   logic [15:0] dig;
   int total = 0;
   int bad   = 0;

   assign dig = {bus.in3, bus.in2, bus.in1, bus.in0};

   function automatic logic [15:0] model(input logic [7:0] p, input logic pl, input logic [1:0] tk);
      int s;
      s = (p > 8'd99) ? 99 : int'(p);
      return {4'(int'(pl) + 1), 4'(tk), 4'(s / 10), 4'(s % 10)};
   endfunction

   // Called at a falling edge; returns at the falling edge after the accept edge.
   task automatic accept(input logic [7:0] p, input logic pl, input logic [1:0] tk, input logic go);
      bus.pile      = p;
      bus.player    = pl;
      bus.take      = tk;
      bus.game_over = go;
      bus.upd_valid = 1'b1;
      sb.push_back(model(p, pl, tk));
      @(negedge clk);
      bus.upd_valid = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (bus.busy === 1'b1 && n < 30) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      #1;
      total++;
      if ({dig, bus.blank, bus.busy} !== 21'd0) begin
         bad++;
         $display("FAIL reset_state: got %h exp 0", {dig, bus.blank, bus.busy});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_normal;
      int n;
      logic [15:0] exp;
      accept(8'd37, 1'b0, 2'd2, 1'b0);
      wait_idle(n);
      total++;
      if (n !== 9) begin bad++; $display("FAIL normal_busy_cycles: got %0d exp 9", n); end
      exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
      total++;
      if (dig !== exp) begin bad++; $display("FAIL normal_digits: got %h exp %h", dig, exp); end
      total++;
      if (bus.blank !== 4'h0) begin bad++; $display("FAIL normal_blank: got %h exp 0", bus.blank); end
   endtask

   task automatic test_async_reset;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({dig, bus.blank, bus.busy} !== 21'd0) begin
         bad++;
         $display("FAIL async_reset: got %h exp 0", {dig, bus.blank, bus.busy});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_boundary;
      logic [7:0] piles[4] = '{8'd150, 8'd0, 8'd99, 8'd10};
      int n;
      logic [15:0] exp;
      for (int i = 0; i < 4; i++) begin
         accept(piles[i], 1'(i), 2'(i), 1'b0);
         wait_idle(n);
         total++;
         if (n !== 9) begin bad++; $display("FAIL boundary_busy[%0d]: got %0d exp 9", i, n); end
         exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
         total++;
         if (dig !== exp) begin bad++; $display("FAIL boundary_digits[%0d]: got %h exp %h", i, dig, exp); end
      end
   endtask

   task automatic test_busy_drop;
      int n;
      logic [15:0] exp;
      logic saw_busy;
      accept(8'd37, 1'b1, 2'd3, 1'b0);
      @(negedge clk);
      @(negedge clk);
      bus.pile      = 8'd5;
      bus.upd_valid = 1'b1;
      @(negedge clk);
      bus.upd_valid = 1'b0;
      wait_idle(n);
      total++;
      if (n !== 6) begin bad++; $display("FAIL drop_busy_tail: got %0d exp 6", n); end
      exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
      total++;
      if (dig !== exp) begin bad++; $display("FAIL drop_digits: got %h exp %h", dig, exp); end
      saw_busy = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (bus.busy !== 1'b0) saw_busy = 1'b1;
         @(negedge clk);
      end
      total++;
      if (saw_busy !== 1'b0) begin bad++; $display("FAIL drop_no_second_conv: got busy exp idle"); end
      total++;
      if (dig !== exp) begin bad++; $display("FAIL drop_digits_hold: got %h exp %h", dig, exp); end
   endtask

   task automatic test_win_blink;
      int n;
      logic [15:0] exp;
      logic [3:0] exp_blank;
      accept(8'd0, 1'b1, 2'd1, 1'b1);
      wait_idle(n);
      total++;
      if (n !== 9) begin bad++; $display("FAIL win_busy_cycles: got %0d exp 9", n); end
      exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
      total++;
      if (dig !== exp) begin bad++; $display("FAIL win_digits: got %h exp %h", dig, exp); end
      for (int k = 0; k < 28; k++) begin
         exp_blank = (k < 4 * WIN_TOGGLES && ((k / BLINK_DIV) % 2) == 1) ? 4'hF : 4'h0;
         total++;
         if (bus.blank !== exp_blank) begin
            bad++;
            $display("FAIL win_blank[%0d]: got %h exp %h", k, bus.blank, exp_blank);
         end
         @(negedge clk);
      end
      accept(8'd0, 1'b1, 2'd1, 1'b1);
      wait_idle(n);
      void'(sb.pop_front());
      for (int k = 0; k < 4; k++) @(negedge clk);
      total++;
      if (bus.blank !== 4'hF) begin bad++; $display("FAIL win_blank_on: got %h exp f", bus.blank); end
      accept(8'd50, 1'b0, 2'd0, 1'b0);
      total++;
      if ({bus.blank, bus.busy} !== 5'b0000_1) begin
         bad++;
         $display("FAIL win_accept_clears: got blank=%h busy=%b exp blank=0 busy=1", bus.blank, bus.busy);
      end
      wait_idle(n);
      total++;
      if (n !== 9) begin bad++; $display("FAIL win_reaccept_busy: got %0d exp 9", n); end
      exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
      total++;
      if (dig !== exp) begin bad++; $display("FAIL win_reaccept_digits: got %h exp %h", dig, exp); end
   endtask

   task automatic test_reset_mid_conv;
      int n;
      logic [15:0] exp;
      accept(8'd64, 1'b0, 2'd1, 1'b0);
      void'(sb.pop_back());
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({dig, bus.blank, bus.busy} !== 21'd0) begin
         bad++;
         $display("FAIL midconv_reset: got %h exp 0", {dig, bus.blank, bus.busy});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      accept(8'd21, 1'b0, 2'd3, 1'b0);
      wait_idle(n);
      total++;
      if (n !== 9) begin bad++; $display("FAIL midconv_busy: got %0d exp 9", n); end
      exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
      total++;
      if (dig !== exp) begin bad++; $display("FAIL midconv_digits: got %h exp %h", dig, exp); end
   endtask

   initial begin
      bus.upd_valid = 1'b0;
      bus.pile      = '0;
      bus.player    = 1'b0;
      bus.take      = '0;
      bus.game_over = 1'b0;
      test_reset;
      test_normal;
      test_async_reset;
      test_boundary;
      test_busy_drop;
      test_win_blink;
      test_reset_mid_conv;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nim_display_formatter.md
Name: nim_display_formatter

Overview:
Upstream feeder for the 4-digit seven-segment updater. Takes game-state snapshots from the Nim game controller and produces the four hex digit codes in3..in0. Digits show player number, last move and remaining pile in decimal. Provides a per-digit blank mask so the downstream stage can flash the winner display at game end. Pile count is converted to decimal with a sequential binary-to-BCD converter.

Parameters:
BLINK_DIV, 25_000_000, clock cycles per blink half-period; 0.25 s at 100 MHz; must be >= 2.
WIN_TOGGLES, 6, number of blank-mask toggles in WIN before the display holds steady; must be even and >= 2.

Ports:
clk  input  1  system clock, 100 MHz on Basys3
rst_n  input  1  asynchronous active-low reset
upd_valid  input  1  one-cycle strobe; new game state on the inputs below
pile  input  8  stones remaining, unsigned binary
player  input  1  player to move (0 = P1, 1 = P2), or winner when game_over = 1
take  input  2  stones taken on last move, 0..3
game_over  input  1  pile exhausted; player is the winner
busy  output  1  conversion in progress; upd_valid is ignored while high
in3  output  4  player digit, 1 or 2
in2  output  4  last-move digit, 0..3
in1  output  4  pile tens digit, BCD
in0  output  4  pile ones digit, BCD
blank  output  4  per-digit blank, active high; bit n blanks in<n>

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; in3..in0 = 0; blank = 0; busy = 0.
  - Blink and shift counters cleared.
  - Takes effect mid-conversion or mid-blink; no partial update survives.
- States: IDLE, CONV, SHOW, WIN.
- Accept: upd_valid = 1 while busy = 0 (state IDLE, SHOW or WIN). The accepting edge E0 does all of the following:
  - Captures player, take and game_over.
  - Captures sat(pile) = min(pile, 99).
  - Sets state = CONV and busy = 1.
  - Sets blank = 0 and clears the blink counter.
- upd_valid while busy = 1 is dropped; no queuing, no effect.
- CONV:
  - Double-dabble on the 8-bit saturated value, one shift per edge, E1..E8.
  - Add-3 correction is applied to each BCD nibble >= 5 before each shift.
  - in3..in0 hold their previous values throughout.
- Edge E9:
  - in3 = player + 1; in2 = take; in1 = tens; in0 = ones.
  - busy = 0.
  - state = SHOW if game_over = 0, else WIN.
  - Outputs are valid 9 edges after acceptance; busy is high for exactly 9 cycles.
- SHOW: outputs static, blank = 0; waits for next accept.
- WIN:
  - Blink counter counts 0..BLINK_DIV-1.
  - At terminal count, blank toggles between 4'b0000 and 4'b1111, starting visible (0000) for the first half-period.
  - After WIN_TOGGLES toggles, blank is held at 0000 and the counter stops.
  - State stays WIN until the next accept.
  - An accept during blinking restarts normally at E0.
- Width rules:
  - Digits are always 0..9 except in3, which is in 1..2.
  - pile > 99 saturates to 9,9; pile = 0 gives 0,0.
  - take is passed through unchanged.
- Simultaneous events: an accept edge coinciding with a blink terminal count resolves to the accept (blank = 0, counter cleared).

Decomposition:
- Package nim_disp_pkg:
  - State enum (IDLE, CONV, SHOW, WIN).
  - Constants MAX_PILE = 99, BIN_W = 8, BCD_W = 4, CONV_CYCLES = 8.
- Sub-module nim_bin2bcd:
  - Sequential 8-bit to 2-digit BCD double-dabble.
  - Interface: start, bin[7:0], done, tens, ones.
  - Owns the shift counter.
- The top FSM owns capture, the blink timer and output registers.

Test Plan:
(Bench parameters: BLINK_DIV = 4, WIN_TOGGLES = 4.)
1. Reset: assert rst_n = 0 asynchronously between clock edges -> in3..in0 = 0, blank = 0, busy = 0 immediately, before the next edge.
2. Normal update: upd_valid with pile = 37, player = 0, take = 2, game_over = 0 -> busy = 1 for 9 cycles, then in3 = 1, in2 = 2, in1 = 3, in0 = 7, blank = 0.
3. Boundary piles: pile = 150 -> in1 = 9, in0 = 9; then pile = 0 -> in1 = 0, in0 = 0; pile = 99 -> 9, 9; pile = 10 -> 1, 0.
4. Busy drop: accept pile = 37; 3 cycles later pulse upd_valid with pile = 5 -> final in1 = 3, in0 = 7; busy falls at cycle 9; no second conversion.
5. Win blink: game_over = 1, player = 1, take = 1, pile = 0 -> in3 = 2, in2 = 1, in1 = 0, in0 = 0. Then, with the counter starting at E9, blank sequence per 4-cycle half-period is 0000, 1111, 0000, 1111, then 0000 forever. A new accept during the 1111 phase forces blank = 0000 at the accept edge.
6. Reset mid-CONV: accept pile = 64, drop rst_n on cycle 4 -> outputs = 0, busy = 0. After release, accept pile = 21 -> in1 = 2, in0 = 1 after 9 cycles.
